dtr_pulse_gen: RTL and testbench

DTR_PULSE_GEN -- requirements
Module: dtr_pulse_gen

---
 rtl/dtr_pkg.sv | 20 ++
 rtl/dtr_pulse_gen_if.sv | 32 +++
 rtl/dtr_down_counter.sv | 43 ++++
 rtl/dtr_pulse_gen.sv | 146 ++++++++++++++
 tb/tb_dtr_pulse_gen.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dtr_pkg.sv
// Shared DTR definitions: FSM state encodings, default widths and a state helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dtr_pkg;

  // Default widths for the duration inputs/counter and the pulse counter.
  localparam int DTR_CNT_W_DEF     = 16;
  localparam int DTR_CNT_SAT_W_DEF = 8;

  // Pulse FSM encodings. The DTR receive/reset logic decodes the same values.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOW   = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  // True while a pulse is in progress (DTR low phase or post-pulse holdoff).
  function automatic logic dtr_state_busy(input logic [1:0] st);
    return (st == ST_LOW) || (st == ST_GUARD);
  endfunction

endpackage

// File: rtl/dtr_pulse_gen_if.sv
// Request/status bundle between a DTR pulse requester (master) and dtr_pulse_gen (slave).
// Latency: n/a (wires only).
// Backpressure: none; requests arriving while busy are dropped and flagged, not stalled.
//   master drives: req, low_cycles, guard_cycles
//   slave drives : dtr, busy, done, dropped, pulse_count
interface dtr_pulse_gen_if
  import dtr_pkg::*;
#(
  parameter int CNT_W     = DTR_CNT_W_DEF,
  parameter int CNT_SAT_W = DTR_CNT_SAT_W_DEF
);

  logic                 req;
  logic [CNT_W-1:0]     low_cycles;
  logic [CNT_W-1:0]     guard_cycles;
  logic                 dtr;
  logic                 busy;
  logic                 done;
  logic                 dropped;
  logic [CNT_SAT_W-1:0] pulse_count;

  modport master (
    output req, low_cycles, guard_cycles,
    input  dtr, busy, done, dropped, pulse_count
  );

  modport slave (
    input  req, low_cycles, guard_cycles,
    output dtr, busy, done, dropped, pulse_count
  );

endinterface

// File: rtl/dtr_down_counter.sv
// Loadable down-counter with an expire flag; timer for both the LOW and GUARD phases.
// Latency: load/decrement visible one cycle after the edge; expire is a decode of the register.
// Backpressure: none; load wins over dec, and the count holds at zero.
//   clk, nreset : clock, async active-low reset (count clears to 0)
//   load/load_val, dec : controls;  count, expire : register value and (count == 0)
module dtr_down_counter
  import dtr_pkg::*;
#(
  parameter int CNT_W = DTR_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign expire = (count_q == '0);

endmodule

// File: rtl/dtr_pulse_gen.sv
// DTR pulse generator: on req drives dtr low for max(low_cycles,1) cycles, then holds off guard_cycles.
// Latency: dtr falls on the accepting edge; done is flagged in the last busy cycle (or LOW-exit edge if guard=0).
// Backpressure: none; req while busy is discarded and reported on dropped, one pulse per cycle.
//   clk, nreset : clock, async active-low reset (aborts any pulse in progress)
//   bus (slave) : req/low_cycles/guard_cycles in; dtr/busy/done/dropped/pulse_count out, all registered
module dtr_pulse_gen
  import dtr_pkg::*;
#(
  parameter int CNT_W     = DTR_CNT_W_DEF,
  parameter int CNT_SAT_W = DTR_CNT_SAT_W_DEF
) (
  input  logic            clk,
  input  logic            nreset,
  dtr_pulse_gen_if.slave  bus
);

  logic [1:0]           state_q,       state_d;
  logic [CNT_W-1:0]     guard_q,       guard_d;
  logic                 dtr_q,         dtr_d;
  logic                 busy_q,        busy_d;
  logic                 done_q,        done_d;
  logic                 dropped_q,     dropped_d;
  logic [CNT_SAT_W-1:0] pulse_count_q, pulse_count_d;

  logic                 cnt_load;
  logic [CNT_W-1:0]     cnt_load_val;
  logic                 cnt_dec;
  logic [CNT_W-1:0]     cnt_val;
  logic                 cnt_expire;
  logic                 pulse_done;

  // Counter is loaded with (duration - 1): a phase lasts from the load edge
  // until the edge that finds the count at zero.
  dtr_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .nreset   (nreset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt_val),
    .expire   (cnt_expire)
  );

  always_comb begin
    state_d       = state_q;
    guard_d       = guard_q;
    dtr_d         = dtr_q;
    busy_d        = busy_q;
    cnt_load      = 1'b0;
    cnt_load_val  = '0;
    cnt_dec       = 1'b0;
    pulse_done    = 1'b0;
    dropped_d     = bus.req && dtr_state_busy(state_q);

    case (state_q)
      ST_IDLE: begin
        dtr_d  = 1'b1;
        busy_d = 1'b0;
        if (bus.req) begin
          state_d      = ST_LOW;
          dtr_d        = 1'b0;
          busy_d       = 1'b1;
          // guard duration is latched now so later input changes cannot
          // stretch or shorten the pulse in progress.
          guard_d      = bus.guard_cycles;
          cnt_load     = 1'b1;
          // A zero low duration is treated as one cycle.
          cnt_load_val = (bus.low_cycles == '0) ? '0 : (bus.low_cycles - CNT_W'(1));
        end
      end

      ST_LOW: begin
        if (cnt_expire) begin
          dtr_d = 1'b1;
          if (guard_q == '0) begin
            // No holdoff: finish straight from LOW.
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            pulse_done = 1'b1;
          end else begin
            state_d      = ST_GUARD;
            cnt_load     = 1'b1;
            cnt_load_val = guard_q - CNT_W'(1);
            // With a one-cycle holdoff the first GUARD cycle is also the last.
            pulse_done   = (guard_q == CNT_W'(1));
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_GUARD: begin
        if (cnt_expire) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_dec    = 1'b1;
          // done is registered, so it is raised on the edge that enters the
          // final GUARD cycle and is visible alongside it.
          pulse_done = (cnt_val == CNT_W'(1));
        end
      end

      default: begin
        state_d = ST_IDLE;
        dtr_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    done_d        = pulse_done;
    pulse_count_d = pulse_count_q;
    if (pulse_done && (pulse_count_q != '1)) begin
      pulse_count_d = pulse_count_q + CNT_SAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= ST_IDLE;
      guard_q       <= '0;
      dtr_q         <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      dropped_q     <= 1'b0;
      pulse_count_q <= '0;
    end else begin
      state_q       <= state_d;
      guard_q       <= guard_d;
      dtr_q         <= dtr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      dropped_q     <= dropped_d;
      pulse_count_q <= pulse_count_d;
    end
  end

  assign bus.dtr         = dtr_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.dropped     = dropped_q;
  assign bus.pulse_count = pulse_count_q;

endmodule

// File: tb/tb_dtr_pulse_gen.sv
// Self-checking bench for dtr_pulse_gen: per-cycle scoreboard against a timing model plus scenario checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_dtr_pulse_gen;

  localparam int CW  = 16;
  localparam int SW  = 8;
  localparam int SW2 = 2;

  logic clk = 1'b0;
  logic nreset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dtr_pulse_gen_if #(.CNT_W(CW), .CNT_SAT_W(SW))  bus1 ();
  dtr_pulse_gen_if #(.CNT_W(CW), .CNT_SAT_W(SW2)) bus2 ();

  dtr_pulse_gen #(.CNT_W(CW), .CNT_SAT_W(SW)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus1)
  );

  dtr_pulse_gen #(.CNT_W(CW), .CNT_SAT_W(SW2)) dut_sat (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          dtr;
    logic          busy;
    logic          done;
    logic          dropped;
    logic [SW-1:0] cnt;
    int            e;
  } exp_t;

  exp_t sb[$];

  // Timing model, expressed in absolute edge numbers of each accepted pulse.
  int            m_acc_ok;
  int            m_low_s;
  int            m_low_e;
  int            m_busy_e;
  int            m_done_e;
  logic [SW-1:0] m_cnt;
  logic          m_prev_busy;

  task automatic model_reset();
    m_acc_ok    = 0;
    m_low_s     = -1;
    m_low_e     = -2;
    m_busy_e    = -2;
    m_done_e    = -1;
    m_cnt       = '0;
    m_prev_busy = 1'b0;
  endtask

  // Called at a negedge: drives inputs for the next edge, predicts outputs
  // after that edge, then samples them at the following negedge.
  task automatic run_cycle(input logic r, input int lo, input int gu);
    exp_t x;
    int   e;
    int   l_eff;
    bus1.req          = r;
    bus1.low_cycles   = CW'(lo);
    bus1.guard_cycles = CW'(gu);
    e = cyc + 1;
    x.dropped = r && m_prev_busy;
    if (r && (e >= m_acc_ok)) begin
      l_eff    = (lo == 0) ? 1 : lo;
      m_low_s  = e;
      m_low_e  = e + l_eff - 1;
      m_busy_e = (gu > 0) ? (e + l_eff + gu - 1) : (e + l_eff - 1);
      m_done_e = e + l_eff + ((gu > 0) ? gu : 1) - 1;
      m_acc_ok = e + l_eff + gu + 1;
    end
    x.dtr  = !((e >= m_low_s) && (e <= m_low_e));
    x.busy = (e >= m_low_s) && (e <= m_busy_e);
    x.done = (e == m_done_e);
    if (x.done && (m_cnt != '1)) m_cnt = m_cnt + 1'b1;
    x.cnt = m_cnt;
    x.e   = e;
    m_prev_busy = x.busy;
    sb.push_back(x);

    @(negedge clk);
    x = sb.pop_front();
    n_checks++;
    if (bus1.dtr !== x.dtr) begin
      n_fail++;
      $display("FAIL dtr @edge %0d: got %0b expected %0b", x.e, bus1.dtr, x.dtr);
    end
    n_checks++;
    if (bus1.busy !== x.busy) begin
      n_fail++;
      $display("FAIL busy @edge %0d: got %0b expected %0b", x.e, bus1.busy, x.busy);
    end
    n_checks++;
    if (bus1.done !== x.done) begin
      n_fail++;
      $display("FAIL done @edge %0d: got %0b expected %0b", x.e, bus1.done, x.done);
    end
    n_checks++;
    if (bus1.dropped !== x.dropped) begin
      n_fail++;
      $display("FAIL dropped @edge %0d: got %0b expected %0b", x.e, bus1.dropped, x.dropped);
    end
    n_checks++;
    if (bus1.pulse_count !== x.cnt) begin
      n_fail++;
      $display("FAIL pulse_count @edge %0d: got %0d expected %0d", x.e, bus1.pulse_count, x.cnt);
    end
  endtask

  task automatic test_reset();
    nreset            = 1'b0;
    bus1.req          = 1'b0;
    bus1.low_cycles   = '0;
    bus1.guard_cycles = '0;
    bus2.req          = 1'b0;
    bus2.low_cycles   = '0;
    bus2.guard_cycles = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus1.dtr, bus1.busy, bus1.done, bus1.dropped} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 1000", {bus1.dtr, bus1.busy, bus1.done, bus1.dropped});
    end
    n_checks++;
    if (bus1.pulse_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d expected 0", bus1.pulse_count);
    end
    n_checks++;
    if ({bus2.dtr, bus2.busy, bus2.pulse_count} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_sat_dut: got %b expected 1000", {bus2.dtr, bus2.busy, bus2.pulse_count});
    end
    nreset = 1'b1;
    model_reset();
  endtask

  task automatic test_saturation();
    logic [SW2-1:0] sat_q[$];
    logic [SW2-1:0] want;
    logic           got;
    for (int i = 0; i < 4; i++) begin
      sat_q.push_back(SW2'((i + 1 > 3) ? 3 : i + 1));
      bus2.req          = 1'b1;
      bus2.low_cycles   = CW'(1);
      bus2.guard_cycles = CW'(1);
      @(negedge clk);
      bus2.req = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        if (bus2.done) got = 1'b1;
        else @(negedge clk);
      end
      want = sat_q.pop_front();
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("FAIL sat_done_timeout pulse %0d: got no done expected done", i);
      end else if (bus2.pulse_count !== want) begin
        n_fail++;
        $display("FAIL sat_count pulse %0d: got %0d expected %0d", i, bus2.pulse_count, want);
      end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_basic();
    int lowc  = 0;
    int busyc = 0;
    int donec = 0;
    for (int i = 0; i < 22; i++) begin
      run_cycle(i == 9, 4, 3);
      if (!bus1.dtr) lowc++;
      if (bus1.busy) busyc++;
      if (bus1.done) donec++;
    end
    n_checks++;
    if (lowc != 4) begin
      n_fail++;
      $display("FAIL basic_low_len: got %0d expected 4", lowc);
    end
    n_checks++;
    if (busyc != 7) begin
      n_fail++;
      $display("FAIL basic_busy_len: got %0d expected 7", busyc);
    end
    n_checks++;
    if (donec != 1) begin
      n_fail++;
      $display("FAIL basic_done_count: got %0d expected 1", donec);
    end
    n_checks++;
    if (bus1.pulse_count !== 8'd1) begin
      n_fail++;
      $display("FAIL basic_pulse_count: got %0d expected 1", bus1.pulse_count);
    end
  endtask

  task automatic test_zero();
    int   lowc = 0;
    int   rise = -1;
    int   dn   = -1;
    logic seen_low = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_cycle(i == 0, 0, 0);
      if (!bus1.dtr) begin
        lowc++;
        seen_low = 1'b1;
      end else if (seen_low && rise < 0) begin
        rise = cyc;
      end
      if (bus1.done && dn < 0) dn = cyc;
    end
    n_checks++;
    if (lowc != 1) begin
      n_fail++;
      $display("FAIL zero_low_len: got %0d expected 1", lowc);
    end
    n_checks++;
    if (rise < 0 || dn != rise) begin
      n_fail++;
      $display("FAIL zero_done_edge: got %0d expected %0d", dn, rise);
    end
  endtask

  task automatic test_back_to_back();
    logic prev_dtr  = 1'b1;
    int   last_fall = -1;
    int   nfalls    = 0;
    for (int i = 0; i < 40; i++) begin
      run_cycle(1'b1, 5, 2);
      if (prev_dtr && !bus1.dtr) begin
        if (last_fall >= 0) begin
          n_checks++;
          if (cyc - last_fall != 8) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d expected 8", cyc - last_fall);
          end
        end
        last_fall = cyc;
        nfalls++;
      end
      prev_dtr = bus1.dtr;
    end
    n_checks++;
    if (nfalls != 5) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %0d expected 5", nfalls);
    end
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 5, 2);
  endtask

  task automatic test_latch();
    int low1 = 0;
    int low2 = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) run_cycle(1'b1, 6, 2);
      else        run_cycle(1'b0, 2, 5);
      if (!bus1.dtr) low1++;
    end
    for (int i = 0; i < 10; i++) begin
      run_cycle(i == 0, 2, 5);
      if (!bus1.dtr) low2++;
    end
    n_checks++;
    if (low1 != 6) begin
      n_fail++;
      $display("FAIL latch_first_low: got %0d expected 6", low1);
    end
    n_checks++;
    if (low2 != 2) begin
      n_fail++;
      $display("FAIL latch_second_low: got %0d expected 2", low2);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    model_reset();
    run_cycle(1'b1, 10, 3);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 10, 3);
    n_checks++;
    if (bus1.dtr !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_precondition_dtr: got %0b expected 0", bus1.dtr);
    end
    #1 nreset = 1'b0;
    #1;
    n_checks++;
    if ({bus1.dtr, bus1.busy, bus1.done} !== 3'b100) begin
      n_fail++;
      $display("FAIL midrst_immediate: got %b expected 100", {bus1.dtr, bus1.busy, bus1.done});
    end
    n_checks++;
    if (bus1.pulse_count !== 8'd0) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d expected 0", bus1.pulse_count);
    end
    @(negedge clk);
    nreset = 1'b1;
    model_reset();
    for (int i = 0; i < 15; i++) run_cycle(1'b0, 10, 3);
    for (int i = 0; i < 8; i++) run_cycle(i == 0, 3, 1);
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_basic();
    test_zero();
    test_back_to_back();
    test_latch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
